// File: rtl/sprite_pos_scheduler.sv
// Frame-synchronous sprite position scheduler: buffers SPI position
// packets per sprite and commits them together on the new-frame pulse.
// Ports:
//   clk_in       rising-edge clock
//   rst_in       synchronous active-high reset
//   data_in      {id, x[10:0], y[9:0]} position packet
//   new_data_in  strobe, data_in valid this cycle
//   nf_in        new-frame pulse, commits pending positions
//   x_out        committed x, 11 bits per sprite
//   y_out        committed y, 10 bits per sprite
//   visible_out  per-sprite render enable
//   commit_out   pulse, committed outputs updated
//   drop_out     pulse, previous packet had an invalid id
module sprite_pos_scheduler #(
  parameter int NUM_SPRITES    = 4,
  parameter int WIDTH          = 1280,
  parameter int HEIGHT         = 720,
  parameter int BOX_DIM        = 128,
  parameter int TIMEOUT_FRAMES = 30,
  parameter int RESET_X        = 320,
  parameter int RESET_Y        = 180,
  localparam int ID_W =
    (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [ID_W+20:0]         data_in,
  input  logic                     new_data_in,
  input  logic                     nf_in,
  output logic [NUM_SPRITES*11-1:0] x_out,
  output logic [NUM_SPRITES*10-1:0] y_out,
  output logic [NUM_SPRITES-1:0]   visible_out,
  output logic                     commit_out,
  output logic                     drop_out
);

  localparam logic [11:0] X_MAX = 12'(WIDTH - BOX_DIM);
  localparam logic [11:0] Y_MAX = 12'(HEIGHT - BOX_DIM);
  localparam logic [7:0]  TO    = 8'(TIMEOUT_FRAMES);
  localparam logic [ID_W:0] NS  = (ID_W + 1)'(NUM_SPRITES);
  localparam logic [10:0] RX    = 11'(RESET_X);
  localparam logic [9:0]  RY    = 10'(RESET_Y);

  logic [ID_W-1:0] pkt_id;
  logic [10:0]     pkt_x;
  logic [9:0]      pkt_y;
  logic            id_ok;
  logic [10:0]     clamp_x;
  logic [9:0]      clamp_y;

  assign pkt_id = data_in[ID_W+20:21];
  assign pkt_x  = data_in[20:10];
  assign pkt_y  = data_in[9:0];
  assign id_ok  = {1'b0, pkt_id} < NS;

  // 12-bit compares keep the clamp free of wrap-around
  assign clamp_x = ({1'b0, pkt_x} > X_MAX) ? X_MAX[10:0] : pkt_x;
  assign clamp_y = ({2'b0, pkt_y} > Y_MAX) ? Y_MAX[9:0] : pkt_y;

  logic [10:0] shx   [NUM_SPRITES];
  logic [9:0]  shy   [NUM_SPRITES];
  logic [10:0] xq    [NUM_SPRITES];
  logic [9:0]  yq    [NUM_SPRITES];
  logic [7:0]  stale [NUM_SPRITES];
  logic [7:0]  st_nx [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] pend;
  logic [NUM_SPRITES-1:0] seen;

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      st_nx[i] = (stale[i] < TO) ? stale[i] + 8'd1 : stale[i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shx[i]   <= RX;
        shy[i]   <= RY;
        xq[i]    <= RX;
        yq[i]    <= RY;
        stale[i] <= 8'd0;
      end
      pend        <= '0;
      seen        <= '0;
      visible_out <= '0;
      commit_out  <= 1'b0;
      drop_out    <= 1'b0;
    end else begin
      commit_out <= nf_in;
      drop_out   <= new_data_in && !id_ok;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (nf_in) begin
          if (pend[i]) begin
            xq[i]          <= shx[i];
            yq[i]          <= shy[i];
            stale[i]       <= 8'd0;
            seen[i]        <= 1'b1;
            pend[i]        <= 1'b0;
            visible_out[i] <= 1'b1;
          end else begin
            stale[i]       <= st_nx[i];
            visible_out[i] <= seen[i] && (st_nx[i] < TO);
          end
        end
        // A packet arriving with nf_in lands after the commit,
        // so its pending set overrides the commit's clear
        if (new_data_in && id_ok && pkt_id == ID_W'(i)) begin
          shx[i]  <= clamp_x;
          shy[i]  <= clamp_y;
          pend[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
    assign x_out[11*g +: 11] = xq[g];
    assign y_out[10*g +: 10] = yq[g];
  end

endmodule
